// File: rtl/uart_rx_fifo.sv
// UART receiver with 3-sample majority voting, parity/framing/break
// detection and a show-ahead frame FIFO for the host command parser.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          i_Clock,
    input  logic                          i_Rst_L,
    input  logic                          i_RX_Serial,
    input  logic                          i_RX_Rd,
    output logic                          o_RX_DV,
    output logic [DATA_BITS-1:0]          o_RX_Data,
    output logic                          o_Parity_Err,
    output logic                          o_Frame_Err,
    output logic                          o_Overrun,
    output logic                          o_Break,
    output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count
);

    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int H    = CLKS_PER_BIT / 2;
    localparam int BW   = $clog2(DATA_BITS);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = PW + 1;
    localparam int EW   = DATA_BITS + 2;

    localparam logic [CW-1:0] C_HM1  = CW'(H - 1);
    localparam logic [CW-1:0] C_H    = CW'(H);
    localparam logic [CW-1:0] C_HP1  = CW'(H + 1);
    localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
    localparam logic          S_LAST = 1'(STOP_BITS - 1);
    localparam logic [CNTW-1:0] C_FULL = CNTW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BWAIT
    } state_t;

    state_t state_q;
    state_t state_d;

    logic                 rx_meta;
    logic                 rx_s;
    logic [CW-1:0]        cnt;
    logic                 smp0;
    logic                 smp1;
    logic                 maj;
    logic                 at_dec;
    logic                 at_wrap;
    logic [BW-1:0]        bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_err;
    logic                 frm_err;
    logic                 all_zero;

    logic                 frame_done;
    logic                 is_brk;
    logic                 fe_now;
    logic                 par_calc;
    logic                 cnt_clr;
    logic                 dec_bit;

    logic                 push_req;
    logic [EW-1:0]        push_word;
    logic                 brk_q;

    logic [EW-1:0]        mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [CNTW-1:0]      count;
    logic                 ovr_q;
    logic                 full;
    logic                 do_pop;
    logic                 do_push;
    logic [EW-1:0]        head;

    assign at_dec  = (cnt == C_HP1);
    assign at_wrap = (cnt == C_LAST);
    assign maj     = (smp0 & smp1) | (smp0 & rx_s) | (smp1 & rx_s);

    // Two-flop synchroniser for the asynchronous RX pin, idling high
    always_ff @(posedge i_Clock) begin
        if (i_Rst_L) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_RX_Serial;
            rx_s    <= rx_meta;
        end
    end

    // Receiver state register
    always_ff @(posedge i_Clock) begin
        if (i_Rst_L) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic: bit decisions at H+1, bit advance at count wrap
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!rx_s) state_d = S_START;
            end
            S_START: begin
                if (at_dec && maj)  state_d = S_IDLE;
                else if (at_wrap)   state_d = S_DATA;
            end
            S_DATA: begin
                if (at_wrap && bit_idx == B_LAST)
                    state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (at_wrap) state_d = S_STOP;
            end
            S_STOP: begin
                if (at_dec && stop_idx == S_LAST)
                    state_d = is_brk ? S_BWAIT : S_IDLE;
            end
            S_BWAIT: begin
                if (rx_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Frame-level strobes derived from the current state and bit decision
    always_comb begin
        frame_done = (state_q == S_STOP) && at_dec && (stop_idx == S_LAST);
        is_brk     = all_zero && !maj;
        fe_now     = frm_err || !maj;
        par_calc   = (PARITY == 2) ? (^{shreg, maj}) : !(^{shreg, maj});
        dec_bit    = at_dec && ((state_q == S_DATA) ||
                                (state_q == S_PARITY) ||
                                (state_q == S_STOP));
        cnt_clr    = (state_q == S_IDLE) || (state_q == S_BWAIT) ||
                     (state_d == S_IDLE) || at_wrap;
    end

    // Bit timing, sampling, shift register and error accumulation
    always_ff @(posedge i_Clock) begin
        if (i_Rst_L) begin
            cnt       <= '0;
            smp0      <= 1'b1;
            smp1      <= 1'b1;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            shreg     <= '0;
            par_err   <= 1'b0;
            frm_err   <= 1'b0;
            all_zero  <= 1'b1;
            push_req  <= 1'b0;
            push_word <= '0;
            brk_q     <= 1'b0;
        end else begin
            push_req <= frame_done;
            brk_q    <= frame_done && is_brk;
            if (frame_done)
                push_word <= {fe_now, par_err, shreg};
            cnt <= cnt_clr ? '0 : cnt + CW'(1);
            if (cnt == C_HM1) smp0 <= rx_s;
            if (cnt == C_H)   smp1 <= rx_s;
            if (state_q == S_IDLE) begin
                bit_idx  <= '0;
                stop_idx <= 1'b0;
                par_err  <= 1'b0;
                frm_err  <= 1'b0;
                all_zero <= 1'b1;
            end
            if (state_q == S_DATA && at_dec)
                shreg <= {maj, shreg[DATA_BITS-1:1]};
            if (state_q == S_DATA && at_wrap)
                bit_idx <= bit_idx + BW'(1);
            if (dec_bit && maj)
                all_zero <= 1'b0;
            if (state_q == S_PARITY && at_dec)
                par_err <= par_calc;
            if (state_q == S_STOP && at_dec && !maj)
                frm_err <= 1'b1;
            if (state_q == S_STOP && at_wrap)
                stop_idx <= stop_idx + 1'b1;
        end
    end

    assign full    = (count == C_FULL);
    assign do_pop  = i_RX_Rd && (count != '0);
    assign do_push = push_req && (!full || do_pop);

    // FIFO pointers, occupancy and overrun pulse
    always_ff @(posedge i_Clock) begin
        if (i_Rst_L) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovr_q  <= 1'b0;
        end else begin
            ovr_q <= push_req && full && !do_pop;
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end

    // Frame storage; contents are only visible while non-empty
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_L && do_push)
            mem[wr_ptr] <= push_word;
    end

    assign head         = mem[rd_ptr];
    assign o_RX_DV      = (count != '0);
    assign o_RX_Data    = o_RX_DV ? head[DATA_BITS-1:0] : '0;
    assign o_Parity_Err = o_RX_DV ? head[DATA_BITS]     : 1'b0;
    assign o_Frame_Err  = o_RX_DV ? head[DATA_BITS+1]   : 1'b0;
    assign o_Overrun    = ovr_q;
    assign o_Break      = brk_q;
    assign o_Fifo_Count = count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: an 8N1 instance and an
// even-parity instance, both at 16 clocks per bit.
module tb_uart_rx_fifo;

    localparam int CPB = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst  = 1'b1;
    logic rx_a = 1'b1;
    logic rd_a = 1'b0;
    logic rx_b = 1'b1;
    logic rd_b = 1'b0;

    logic       dv_a, pe_a, fe_a, ovr_a, brk_a;
    logic [7:0] data_a;
    logic [2:0] cnt_a;
    logic       dv_b, pe_b, fe_b, ovr_b, brk_b;
    logic [7:0] data_b;
    logic [2:0] cnt_b;

    int n_cmp = 0;
    int n_bad = 0;
    int ovr_cnt = 0;
    int brk_cnt = 0;

    logic [9:0] q_a[$];
    logic [9:0] q_b[$];

    uart_rx_fifo #(
        .CLKS_PER_BIT(CPB)
    ) u_dut_a (
        .i_Clock      (clk),
        .i_Rst_L      (rst),
        .i_RX_Serial  (rx_a),
        .i_RX_Rd      (rd_a),
        .o_RX_DV      (dv_a),
        .o_RX_Data    (data_a),
        .o_Parity_Err (pe_a),
        .o_Frame_Err  (fe_a),
        .o_Overrun    (ovr_a),
        .o_Break      (brk_a),
        .o_Fifo_Count (cnt_a)
    );

    uart_rx_fifo #(
        .CLKS_PER_BIT(CPB),
        .PARITY(2)
    ) u_dut_b (
        .i_Clock      (clk),
        .i_Rst_L      (rst),
        .i_RX_Serial  (rx_b),
        .i_RX_Rd      (rd_b),
        .o_RX_DV      (dv_b),
        .o_RX_Data    (data_b),
        .o_Parity_Err (pe_b),
        .o_Frame_Err  (fe_b),
        .o_Overrun    (ovr_b),
        .o_Break      (brk_b),
        .o_Fifo_Count (cnt_b)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor A: compare the head entry against the scoreboard on each pop
    always @(negedge clk) begin
        if (ovr_a) ovr_cnt++;
        if (brk_a) brk_cnt++;
        if (rd_a && dv_a) begin
            if (q_a.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL pop_a_unexpected: got %0h expected none",
                         {fe_a, pe_a, data_a});
            end else begin
                chk("pop_a", 32'({fe_a, pe_a, data_a}), 32'(q_a.pop_front()));
            end
        end
    end

    // Monitor B
    always @(negedge clk) begin
        if (rd_b && dv_b) begin
            if (q_b.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL pop_b_unexpected: got %0h expected none",
                         {fe_b, pe_b, data_b});
            end else begin
                chk("pop_b", 32'({fe_b, pe_b, data_b}), 32'(q_b.pop_front()));
            end
        end
    end

    task automatic drive(input int which, input logic v);
        if (which == 0) rx_a = v;
        else            rx_b = v;
    endtask

    task automatic hold(input int which, input logic v, input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #2;
            drive(which, v);
        end
    endtask

    task automatic send(input int which, input logic [7:0] d,
                        input int npar, input logic pbit, input int spike);
        logic [10:0] bits;
        int nb;
        nb = 0;
        bits = '1;
        bits[nb] = 1'b0;
        nb++;
        for (int i = 0; i < 8; i++) begin
            bits[nb] = d[i];
            nb++;
        end
        if (npar != 0) begin
            bits[nb] = pbit;
            nb++;
        end
        bits[nb] = 1'b1;
        nb++;
        for (int j = 0; j < nb; j++) begin
            for (int c = 0; c < CPB; c++) begin
                @(posedge clk);
                #2;
                drive(which, bits[j] ^ ((j == spike) && (c == 9)));
            end
        end
    endtask

    task automatic pop(input int which);
        @(posedge clk);
        #2;
        if (which == 0) rd_a = 1'b1;
        else            rd_b = 1'b1;
        @(posedge clk);
        #2;
        rd_a = 1'b0;
        rd_b = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    initial begin
        int ovr0;
        int brk0;
        idle(3);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_dv", 32'(dv_a), 0);
        chk("rst_data", 32'(data_a), 0);
        chk("rst_cnt", 32'(cnt_a), 0);
        chk("rst_pulses", 32'({ovr_a, brk_a, pe_a, fe_a}), 0);

        // Back-to-back 8N1 frames, no reads
        send(0, 8'hA5, 0, 1'b0, -1);
        q_a.push_back(10'h0A5);
        send(0, 8'h3C, 0, 1'b0, -1);
        q_a.push_back(10'h03C);
        idle(4);
        @(negedge clk);
        chk("t1_cnt", 32'(cnt_a), 2);
        chk("t1_dv", 32'(dv_a), 1);
        chk("t1_head", 32'({fe_a, pe_a, data_a}), 32'h0A5);
        pop(0);
        @(negedge clk);
        chk("t1_next", 32'(data_a), 32'h3C);
        pop(0);
        @(negedge clk);
        chk("t1_empty", 32'(cnt_a), 0);

        // Even parity: wrong then correct parity bit
        send(1, 8'h07, 1, 1'b0, -1);
        q_b.push_back(10'h107);
        send(1, 8'h07, 1, 1'b1, -1);
        q_b.push_back(10'h007);
        idle(4);
        @(negedge clk);
        chk("t2_cnt", 32'(cnt_b), 2);
        chk("t2_pe_bad", 32'(pe_b), 1);
        chk("t2_data", 32'(data_b), 32'h07);
        pop(1);
        @(negedge clk);
        chk("t2_pe_ok", 32'(pe_b), 0);
        pop(1);
        @(negedge clk);
        chk("t2_empty", 32'(cnt_b), 0);

        // Short glitch is a false start; spike on a data bit is voted out
        hold(0, 1'b0, 4);
        hold(0, 1'b1, 40);
        @(negedge clk);
        chk("t3_glitch_cnt", 32'(cnt_a), 0);
        send(0, 8'hC3, 0, 1'b0, 3);
        q_a.push_back(10'h0C3);
        idle(4);
        @(negedge clk);
        chk("t3_spike_cnt", 32'(cnt_a), 1);
        pop(0);

        // Overflow: fifth frame dropped with a single overrun pulse
        ovr0 = ovr_cnt;
        for (int k = 1; k <= 5; k++) begin
            send(0, 8'(k), 0, 1'b0, -1);
            if (k <= 4) q_a.push_back(10'(k));
        end
        idle(4);
        @(negedge clk);
        chk("t4_cnt_full", 32'(cnt_a), 4);
        chk("t4_ovr_once", 32'(ovr_cnt - ovr0), 1);
        for (int k = 0; k < 4; k++) pop(0);
        @(negedge clk);
        chk("t4_cnt_empty", 32'(cnt_a), 0);

        // Break: line low 12 bit times, then a normal frame
        brk0 = brk_cnt;
        hold(0, 1'b0, 12 * CPB);
        @(negedge clk);
        chk("t5_brk_once", 32'(brk_cnt - brk0), 1);
        chk("t5_cnt_low", 32'(cnt_a), 1);
        chk("t5_brk_entry", 32'({fe_a, pe_a, data_a}), 32'h200);
        q_a.push_back(10'h200);
        hold(0, 1'b1, 2 * CPB);
        send(0, 8'h55, 0, 1'b0, -1);
        q_a.push_back(10'h055);
        idle(4);
        @(negedge clk);
        chk("t5_cnt", 32'(cnt_a), 2);
        chk("t5_brk_total", 32'(brk_cnt - brk0), 1);
        pop(0);
        pop(0);

        // Reset mid-frame with two entries queued
        send(0, 8'h11, 0, 1'b0, -1);
        send(0, 8'h22, 0, 1'b0, -1);
        idle(4);
        @(negedge clk);
        chk("t6_cnt_pre", 32'(cnt_a), 2);
        hold(0, 1'b0, CPB);
        hold(0, 1'b1, 3 * CPB + 8);
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("t6_rst_outs",
            32'({dv_a, pe_a, fe_a, ovr_a, brk_a, data_a}), 0);
        chk("t6_rst_cnt", 32'(cnt_a), 0);
        idle(2 * CPB);
        @(negedge clk);
        chk("t6_no_push", 32'(cnt_a), 0);
        send(0, 8'h5A, 0, 1'b0, -1);
        q_a.push_back(10'h05A);
        idle(4);
        @(negedge clk);
        chk("t6_cnt_post", 32'(cnt_a), 1);
        pop(0);

        idle(4);
        @(negedge clk);
        chk("q_a_drained", 32'(q_a.size()), 0);
        chk("q_b_drained", 32'(q_b.size()), 0);
        chk("b_no_pulses", 32'({ovr_b, brk_b}), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
